relm_div_seq: RTL and testbench
===============================

RELM_DIV_SEQ -- requirements
Module: relm_div_seq

Interface
REQ-001 Parameter WD, default 32, data word width.
REQ-002 Parameter WOP, default 5, opcode width; x_out bits [WOP+1:WOP] carry the OPB sub-operation select.
REQ-003 clk  input  1  system clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start_in  input  1  request a division; sampled only in IDLE.
REQ-006 n_in, d_in  input  WD each  dividend and divisor, captured when start is accepted.
REQ-007 busy_out  output  1  high from the cycle after acceptance until done_out.
REQ-008 done_out  output  1  one-cycle pulse; result valid in that cycle.
REQ-009 q_out, r_out  output  WD each  quotient and remainder; held until the next acceptance.
REQ-010 div0_out  output  1  divide-by-zero flag; qualified by done_out.
REQ-011 op_out  output  WOP  opcode to the custom unit; bits [2:0] = 3'b101.
REQ-012 opb_out  output  1  OPB qualifier to the custom unit.
REQ-013 x_out  output  WD  operand word to the custom unit; carries the sub-operation select.
REQ-014 a_out, xb_out  output  WD each  A and XB operands to the custom unit.
REQ-015 cb_out  output  3*WD  {D,C,B} registers to the custom unit.
REQ-016 a_in  input  WD  A result returned by the combinational custom unit.
REQ-017 cb_in  input  3*WD  {D,C,B} results returned by the combinational custom unit.

Function
REQ-018 The block owns registers A and {D,C,B}, drives them on a_out and cb_out, and captures a_in and cb_in into them at the end of every issue cycle.
REQ-019 States: IDLE, DIV, INIT, LOOP, MOD, DONE; DONE lasts exactly one cycle and then returns to IDLE.
REQ-020 IDLE with start_in=1 and d_in!=0: load A=n_in and xb_out=d_in, then go to DIV.
REQ-021 IDLE with start_in=1 and d_in=0: go to DONE with q=all-ones, r=n_in, div0=1; latency is 1 cycle.
REQ-022 DIV: issue opb_out=0, which captures D=divisor, C=N, B=one-hot MSB of D, A=one-hot MSB of N.
REQ-023 After DIV, compute k = pos(A) - pos(B).
REQ-024 If B>A: go to DONE with q=0, r=C; total latency is 2 cycles.
REQ-025 Otherwise, load A = one-hot bit k and go to INIT.
REQ-026 INIT: issue opb_out=1 and x_out[WOP+1:WOP]=2'b10.
REQ-027 LOOP: issue opb_out=1 and x_out[WOP+1:WOP]=2'b01.
REQ-028 LOOP repeats until the captured A==0, giving L = floor(k/2)+1 iterations, then goes to MOD.
REQ-029 MOD: issue opb_out=1 and x_out[WOP+1:WOP]=2'b11; q_out=captured A... no: q_out=captured B (quotient Q) and r_out=captured A (remainder N), then go to DONE.
REQ-030 Latency from the accepting edge to done_out is 4+L cycles.
REQ-031 start_in is ignored while busy_out=1.
REQ-032 In IDLE and DONE, op_out[2:0]=3'b101 and opb_out=0 while the captured registers hold their values.
REQ-033 All arithmetic is modulo 2^WD and unsigned unless RELM_DIV_SIGNED_EN is defined.

Reset
REQ-034 rst=1 forces IDLE and clears busy_out, done_out, div0_out, q_out, r_out, A, D, C, B and xb_out to 0, taking priority over all other activity, including mid-LOOP.
REQ-035 The first start_in accepted after reset is handled normally, with no residue from the aborted operation.

Configuration
REQ-036 Macro RELM_DIV_SIGNED_EN defined: operands are two's complement; magnitudes are divided; q is negated when the operand signs differ; r takes the dividend's sign; this adds one cycle at entry and one at exit.
REQ-037 Macro undefined: unsigned division only; no extra cycles.

Verification
REQ-038 n=100, d=7 -> q=14, r=2, div0=0; done_out 7 cycles after acceptance (L=3).
REQ-039 n=5, d=9 -> q=0, r=5; done_out 2 cycles after acceptance; no INIT or LOOP issued.
REQ-040 n=32'hFFFFFFFF, d=1 -> q=32'hFFFFFFFF, r=0; L=16; done_out 20 cycles after acceptance.
REQ-041 n=1234, d=0 -> div0=1, q=32'hFFFFFFFF, r=1234 after 1 cycle; a second start_in during busy_out is ignored.
REQ-042 rst pulsed in the 2nd LOOP cycle of 100/7 -> all outputs read 0 next cycle; a following 100/7 yields q=14, r=2.
REQ-043 With RELM_DIV_SIGNED_EN, n=-7, d=2 -> q=-3 (32'hFFFFFFFD), r=-1 (32'hFFFFFFFF).

Source files
------------

// File: rtl/relm_div_seq.sv
// Sequential divider that drives an external combinational custom unit through
// DIV / INIT / LOOP / MOD issue cycles. Optional signed mode: RELM_DIV_SIGNED_EN.
module relm_div_seq #(
  parameter int WD  = 32,
  parameter int WOP = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_in,
  input  logic [WD-1:0]   n_in,
  input  logic [WD-1:0]   d_in,
  output logic            busy_out,
  output logic            done_out,
  output logic [WD-1:0]   q_out,
  output logic [WD-1:0]   r_out,
  output logic            div0_out,
  output logic [WOP-1:0]  op_out,
  output logic            opb_out,
  output logic [WD-1:0]   x_out,
  output logic [WD-1:0]   a_out,
  output logic [WD-1:0]   xb_out,
  output logic [3*WD-1:0] cb_out,
  input  logic [WD-1:0]   a_in,
  input  logic [3*WD-1:0] cb_in,
  output logic [2:0]      state_dbg
);

  localparam int IW = $clog2(WD);

  // Handshake: start_in is accepted only while busy_out=0 (IDLE); busy_out then
  // stays high through the single done_out cycle, when q/r/div0 are valid.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_DIV  = 3'd1,
    S_INIT = 3'd2,
    S_LOOP = 3'd3,
    S_MOD  = 3'd4,
    S_DONE = 3'd5
`ifdef RELM_DIV_SIGNED_EN
    ,
    S_ABS  = 3'd6,
    S_FIX  = 3'd7
`endif
  } state_t;

  state_t          state;
  logic [WD-1:0]   a_q, b_q, c_q, d_q, xb_q, q_q, r_q;
  logic            busy_q, done_q, div0_q, opb_q;
  logic [1:0]      sel_q;
`ifdef RELM_DIV_SIGNED_EN
  logic            n_neg, q_neg;
`endif

  function automatic logic [IW-1:0] msb_pos(input logic [WD-1:0] v);
    msb_pos = '0;
    for (int i = 0; i < WD; i++)
      if (v[i]) msb_pos = IW'(i);
  endfunction

  logic [WD-1:0] b_in, c_in, d_in_cu, onehot_k;
  logic [IW-1:0] k;
  logic          early;

  assign b_in     = cb_in[WD-1:0];
  assign c_in     = cb_in[2*WD-1:WD];
  assign d_in_cu  = cb_in[3*WD-1:2*WD];
  // Both are one-hot MSB markers, so a plain compare tells whether N < 2^pos(D).
  assign early    = b_in > a_in;
  assign k        = msb_pos(a_in) - msb_pos(b_in);
  assign onehot_k = {{(WD-1){1'b0}}, 1'b1} << k;

  assign busy_out  = busy_q;
  assign done_out  = done_q;
  assign q_out     = q_q;
  assign r_out     = r_q;
  assign div0_out  = div0_q;
  assign op_out    = {{(WOP-3){1'b0}}, 3'b101};
  assign opb_out   = opb_q;
  assign x_out     = {{(WD-WOP-2){1'b0}}, sel_q, {WOP{1'b0}}};
  assign a_out     = a_q;
  assign xb_out    = xb_q;
  assign cb_out    = {d_q, c_q, b_q};
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      a_q    <= '0;
      b_q    <= '0;
      c_q    <= '0;
      d_q    <= '0;
      xb_q   <= '0;
      q_q    <= '0;
      r_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      div0_q <= 1'b0;
      opb_q  <= 1'b0;
      sel_q  <= 2'b00;
`ifdef RELM_DIV_SIGNED_EN
      n_neg  <= 1'b0;
      q_neg  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_in) begin
            busy_q <= 1'b1;
            if (d_in == '0) begin
              q_q    <= '1;
              r_q    <= n_in;
              div0_q <= 1'b1;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              a_q    <= n_in;
              xb_q   <= d_in;
              div0_q <= 1'b0;
`ifdef RELM_DIV_SIGNED_EN
              n_neg  <= n_in[WD-1];
              q_neg  <= n_in[WD-1] ^ d_in[WD-1];
              state  <= S_ABS;
`else
              state  <= S_DIV;
`endif
            end
          end
        end
`ifdef RELM_DIV_SIGNED_EN
        S_ABS: begin
          a_q   <= a_q[WD-1] ? -a_q : a_q;
          xb_q  <= xb_q[WD-1] ? -xb_q : xb_q;
          state <= S_DIV;
        end
`endif
        S_DIV: begin
          d_q <= d_in_cu;
          c_q <= c_in;
          b_q <= b_in;
          if (early) begin
            a_q    <= a_in;
            q_q    <= '0;
            r_q    <= c_in;
`ifdef RELM_DIV_SIGNED_EN
            state  <= S_FIX;
`else
            done_q <= 1'b1;
            state  <= S_DONE;
`endif
          end else begin
            a_q   <= onehot_k;
            opb_q <= 1'b1;
            sel_q <= 2'b10;
            state <= S_INIT;
          end
        end
        S_INIT: begin
          a_q   <= a_in;
          {d_q, c_q, b_q} <= cb_in;
          sel_q <= 2'b01;
          state <= S_LOOP;
        end
        S_LOOP: begin
          a_q <= a_in;
          {d_q, c_q, b_q} <= cb_in;
          // The unit retires two quotient bits per pass; an empty mask means done.
          if (a_in == '0) begin
            sel_q <= 2'b11;
            state <= S_MOD;
          end
        end
        S_MOD: begin
          a_q   <= a_in;
          {d_q, c_q, b_q} <= cb_in;
          q_q   <= b_in;
          r_q   <= a_in;
          opb_q <= 1'b0;
          sel_q <= 2'b00;
`ifdef RELM_DIV_SIGNED_EN
          state <= S_FIX;
`else
          done_q <= 1'b1;
          state  <= S_DONE;
`endif
        end
`ifdef RELM_DIV_SIGNED_EN
        S_FIX: begin
          q_q    <= q_neg ? -q_q : q_q;
          r_q    <= n_neg ? -r_q : r_q;
          done_q <= 1'b1;
          state  <= S_DONE;
        end
`endif
        S_DONE: begin
          busy_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          opb_q  <= 1'b0;
          sel_q  <= 2'b00;
          state  <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_relm_div_seq.sv
// Bench for relm_div_seq: models the combinational custom unit, issues random
// and directed divisions, and scores q/r/div0/latency/issue counts.
module tb_relm_div_seq;
  localparam int WD    = 32;
  localparam int WOP   = 5;
  localparam int EXP_W = 2*WD + 1 + 8 + 8 + 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start_in = 1'b0;
  logic [WD-1:0]   n_in = '0, d_in = '0;
  logic            busy_out, done_out, div0_out, opb_out;
  logic [WD-1:0]   q_out, r_out, x_out, a_out, xb_out;
  logic [WOP-1:0]  op_out;
  logic [3*WD-1:0] cb_out;
  logic [WD-1:0]   cu_a;
  logic [3*WD-1:0] cu_cb;
  logic [2:0]      state_dbg;

  relm_div_seq #(.WD(WD), .WOP(WOP)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .n_in(n_in), .d_in(d_in),
    .busy_out(busy_out), .done_out(done_out), .q_out(q_out), .r_out(r_out),
    .div0_out(div0_out), .op_out(op_out), .opb_out(opb_out), .x_out(x_out),
    .a_out(a_out), .xb_out(xb_out), .cb_out(cb_out), .a_in(cu_a),
    .cb_in(cu_cb), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  function automatic int msb(input logic [WD-1:0] v);
    msb = -1;
    for (int i = 0; i < WD; i++) if (v[i]) msb = i;
  endfunction

  function automatic logic [WD-1:0] onehot_msb(input logic [WD-1:0] v);
    logic [WD-1:0] one;
    one = 1;
    return (v == '0) ? '0 : (one << msb(v));
  endfunction

  // Custom unit: returns {A, D, C, B}. Shift-subtract kernel, two bits per LOOP.
  function automatic logic [4*WD-1:0] cu_eval(input logic opb, input logic [1:0] sel,
      input logic [WD-1:0] a, xb, dd, cc, bb);
    logic [WD-1:0] m, d, r, q;
    m = a; d = dd; r = cc; q = bb;
    if (!opb) return {onehot_msb(a), xb, a, onehot_msb(xb)};
    case (sel)
      2'b10: return {a, dd * a, cc, {WD{1'b0}}};
      2'b01: begin
        for (int s = 0; s < 2; s++)
          if (m != '0) begin
            if (r >= d) begin r = r - d; q = q | m; end
            d = d >> 1;
            m = m >> 1;
          end
        return {m, d, r, q};
      end
      2'b11: return {cc, dd, cc, bb};
      default: return {a, dd, cc, bb};
    endcase
  endfunction

  always_comb
    {cu_a, cu_cb} = cu_eval(opb_out, x_out[WOP+1:WOP], a_out, xb_out,
                            cb_out[3*WD-1:2*WD], cb_out[2*WD-1:WD], cb_out[WD-1:0]);

  // Reference: quotient/remainder by plain arithmetic, timing from the k/L rule.
  function automatic logic [EXP_W-1:0] model(input logic [WD-1:0] n, d, input int acc);
    logic [WD-1:0] q, r, mn, md;
    int lat, nopb, k, extra;
    mn = n; md = d; extra = 0;
`ifdef RELM_DIV_SIGNED_EN
    mn = n[WD-1] ? -n : n;
    md = d[WD-1] ? -d : d;
    extra = 2;
    if (d != '0) begin q = $signed(n) / $signed(d); r = $signed(n) % $signed(d); end
`else
    if (d != '0) begin q = n / d; r = n % d; end
`endif
    if (d == '0) begin
      q = '1; r = n; lat = 1; nopb = 0;
    end else if (mn == '0 || msb(mn) < msb(md)) begin
      lat = 2 + extra; nopb = 0;
    end else begin
      k = msb(mn) - msb(md);
      lat = 4 + k/2 + 1 + extra;
      nopb = k/2 + 1 + 2;
    end
    return {q, r, (d == '0), 8'(lat), 8'(nopb), 32'(acc)};
  endfunction

  task automatic check(input string name, input logic [WD-1:0] act, input logic [WD-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  int opb_cnt = 0;
  logic [WD-1:0] e_q, e_r;
  logic          e_div0;
  logic [7:0]    e_lat, e_opb;
  logic [31:0]   e_acc;
  always @(negedge clk) begin
    if (rst) opb_cnt = 0;
    else begin
      if (opb_out) opb_cnt++;
      if (done_out) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done_out=1 q=%0h expected no pending result", q_out);
        end else begin
          {e_q, e_r, e_div0, e_lat, e_opb, e_acc} = exp_q.pop_front();
          check("quotient", q_out, e_q);
          check("remainder", r_out, e_r);
          check("div0", WD'(div0_out), WD'(e_div0));
          check("latency", WD'(cyc - int'(e_acc)), WD'(e_lat));
          check("opb_issues", WD'(opb_cnt), WD'(e_opb));
          check("op_code", WD'(op_out[2:0]), WD'(3'b101));
        end
        opb_cnt = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [WD-1:0] n, input logic [WD-1:0] d, input int hold);
    int w = 0;
    while (busy_out && w < 200) begin @(posedge clk); #1; w++; end
    if (busy_out) begin
      checks++; errors++;
      $display("FAIL idle_wait: got busy_out=1 after %0d cycles expected 0", w);
      return;
    end
    start_in = 1'b1; n_in = n; d_in = d;
    exp_q.push_back(model(n, d, cyc));
    @(posedge clk); #1;
    if (hold > 1) begin
      n_in = $urandom(); d_in = $urandom();
      @(posedge clk); #1;
    end
    start_in = 1'b0;
  endtask

  task automatic drain();
    int w = 0;
    while ((exp_q.size() != 0 || busy_out) && w < 500) begin @(posedge clk); #1; w++; end
    checks++;
    if (exp_q.size() != 0 || busy_out) begin
      errors++;
      $display("FAIL drain: got %0d pending busy=%0b expected 0 pending busy=0", exp_q.size(), busy_out);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, WD'(busy_out), '0);
    check({tag, "_done"}, WD'(done_out), '0);
    check({tag, "_div0"}, WD'(div0_out), '0);
    check({tag, "_q"}, q_out, '0);
    check({tag, "_r"}, r_out, '0);
    check({tag, "_a"}, a_out, '0);
    check({tag, "_xb"}, xb_out, '0);
    check({tag, "_cb_d"}, cb_out[3*WD-1:2*WD], '0);
    check({tag, "_cb_c"}, cb_out[2*WD-1:WD], '0);
    check({tag, "_cb_b"}, cb_out[WD-1:0], '0);
    check({tag, "_opb"}, WD'(opb_out), '0);
    check({tag, "_op"}, WD'(op_out[2:0]), WD'(3'b101));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [WD-1:0] n, d;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;

    issue(32'd100, 32'd7, 2);
    issue(32'd5, 32'd9, 1);
    issue(32'hFFFF_FFFF, 32'd1, 1);
    issue(32'd1234, 32'd0, 2);
    drain();
    repeat (3) begin @(posedge clk); #1; end
    check("div0_restart_ignored", WD'(busy_out), '0);

    // Abort 100/7 in its second LOOP cycle.
    issue(32'd100, 32'd7, 1);
    repeat (3) begin @(posedge clk); #1; end
    check("midloop_opb", WD'(opb_out), WD'(1));
    check("midloop_sel", WD'(x_out[WOP+1:WOP]), WD'(2'b01));
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midloop_rst");
    @(posedge clk); #1;
    issue(32'd100, 32'd7, 1);
    drain();

`ifdef RELM_DIV_SIGNED_EN
    issue(-32'sd7, 32'd2, 1);
    issue(32'd7, -32'sd2, 1);
    drain();
`endif

    for (int i = 0; i < 150; i++) begin
      n = $urandom() >> $urandom_range(0, 31);
      d = ($urandom_range(0, 9) == 0) ? '0 : ($urandom() >> $urandom_range(0, 31));
      issue(n, d, $urandom_range(1, 2));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout at cycle %0d expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
